niski_dut: RTL and testbench
============================

// Module: niski_dut
// PURPOSE
// - FPGA top of the Niski SoC: minimal multicycle RV32I-subset CPU, instruction ROM, data RAM, MMIO.
// - MMIO drives 4 LEDs and a 4-digit multiplexed hex seven-segment display, and reads 4 user buttons.
// - BTN_PINS[4] is the board reset button.
// PARAMETERS
// - ROM_FILE   "program.hex"  $readmemh image for the 256x32 instruction ROM.
// - SCAN_DIV   1024           clock cycles each seven-segment digit stays selected.
// PORTS
// - CLK_PIN          in   1  single system clock; all state on its rising edge.
// - BTN_PINS         in   5  [4] reset button, low = pressed; [3:0] user buttons, high = pressed.
// - LED_PINS         out  4  LED register, high = lit.
// - SEVSEG_SEG_PINS  out  7  segments {g,f,e,d,c,b,a}, active-low.
// - SEVSEG_SEL_PINS  out  4  digit select, active-low; bit0 = rightmost digit.
// BEHAVIOUR
// - Reset: rst = ~BTN_PINS[4]. One clock; reset is asynchronous and active-high.
// - While rst is high: PC=0, x1..x31=0, LED=0, SEV=0, scan counter/digit=0, FSM=FETCH.
// - Reset outputs: LED_PINS=4'h0, SEL=4'b1110, SEG=7'b1000000 (digit "0").
// - Reset mid-instruction aborts the instruction; any pending store is discarded.
// - x0 reads as 0; writes to x0 are ignored.
// - FSM, states FETCH/EXEC/MEM/WB/HALT.
//   - FETCH: registered ROM read at PC[9:2] -> EXEC.
//   - EXEC: ALU result, branch decision, stores.
//     - Non-load -> writeback, PC update -> FETCH.
//     - Load -> MEM.
//   - MEM: synchronous RAM/MMIO read -> WB.
//   - WB: writeback, PC+=4 -> FETCH.
//   - Timing: non-load = 2 cycles; load = 4 cycles.
// - Supported instructions:
//   - LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE.
//   - LW, SW (word only).
//   - ADDI, SLTI, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
//   - ADD, SUB, SLT, XOR, OR, AND, SLL, SRL, SRA.
// - Halting: any other opcode, ECALL or EBREAK -> HALT. HALT is held until reset; outputs and display scan keep running.
// - Arithmetic: 32-bit two's complement; overflow wraps; shift amount = low 5 bits.
// - Branch/JAL targets: PC-relative. JALR target = (rs1+imm) & ~1. rd = PC+4.
// - Memory map, decoded on address[31:28]; low 2 address bits ignored:
//   - 0x0: ROM 0x000-0x3FF. Read-only; stores ignored. Loads return the word.
//   - 0x1: RAM 256 words at 0x1000_0000. Index [9:2]; wraps above 0x3FF.
//   - 0x2000_0000: LED reg. W [3:0]; R zero-extended.
//   - 0x2000_0004: SEV reg. W [15:0]; R zero-extended.
//   - 0x2000_0008: buttons. R {28'b0, BTN_PINS[3:0]}; unsynchronised sample at MEM.
//   - Unmapped: reads return 0; writes ignored.
// - Seven-segment display:
//   - Digit d (0..3) shows SEV[4d+3:4d] as hex glyph 0-F.
//   - Active-low glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
//     8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
//   - Every SCAN_DIV cycles, digit advances 0->1->2->3->0.
//   - SEL is a one-hot low on bit d; SEG is combinational from the current digit and SEV.
//   - Updated SEV value shows from the next cycle.
// TESTING
// - Reset: BTN_PINS[4]=0 for 2 ns, then 1 -> LED_PINS=0, SEL=1110, SEG=1000000.
//   - After release, first fetch is from ROM[0].
// - LED write: ROM lui x2,0x20000; addi x1,x0,5; sw x1,0(x2) -> LED_PINS=4'b0101 after the sw completes (cycle 6).
// - Display: sw 0x1234 to 0x2000_0004, SCAN_DIV=4 -> SEL cycles 1110,1101,1011,0111 every 4 cycles.
//   - SEG per digit: 0011001("4"), 0110000("3"), 0100100("2"), 1111001("1").
// - Count loop: RAM store/load, addi x1,x1,1, bne back, 16 iterations, result written to LED.
//   - Required: LED=4'h0 (16 mod 16) and SEV=0x0010 within 600 cycles.
// - Buttons/halt: BTN_PINS[3:0]=4'b1010; program lw from 0x2000_0008 and sw to LED -> LED_PINS=1010.
//   - Next word 0x00000000 -> HALT: PC frozen, LED unchanged.
//   - Reset pulse restarts execution from 0.

Source files
------------

// File: rtl/niski_dut_if.sv
// Board-side pin bundle of the Niski SoC: buttons in, LEDs and seven-segment out.
interface niski_dut_if;
  logic [4:0] BTN_PINS;
  logic [3:0] LED_PINS;
  logic [6:0] SEVSEG_SEG_PINS;
  logic [3:0] SEVSEG_SEL_PINS;

  // Board / testbench side
  modport master (
    output BTN_PINS,
    input  LED_PINS, SEVSEG_SEG_PINS, SEVSEG_SEL_PINS
  );

  // SoC side
  modport slave (
    input  BTN_PINS,
    output LED_PINS, SEVSEG_SEG_PINS, SEVSEG_SEL_PINS
  );
endinterface

// File: rtl/niski_dut.sv
// Niski SoC top: multicycle RV32I-subset CPU, 256x32 instruction ROM, 256x32 data RAM,
// MMIO LED register, 16-bit hex display register and button port.
module niski_dut #(
  parameter string ROM_FILE = "program.hex",
  parameter int    SCAN_DIV = 1024
) (
  input logic        CLK_PIN,
  niski_dut_if.slave io
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_OPI = 7'h13, OP_OP = 7'h33;

  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

  logic rst;
  assign rst = ~io.BTN_PINS[4];

  state_t state, state_nx;
  logic [31:0] pc, ir, rdata;
  logic [31:0] regs [0:31];
  logic [31:0] rom  [0:255];
  logic [31:0] ram  [0:255];
  logic [3:0]  led;
  logic [15:0] sev;
  logic [31:2] addr_q;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  digit;

  // Instruction fields and immediates
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, a, b, rs2v;
  assign op  = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign a    = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2v = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign b    = (op == OP_OP) ? rs2v : imm_i;

  // Shared ALU for OP and OP-IMM; SLTIU/SLTU are outside the subset
  logic [31:0] alu;
  logic alu_ok;
  always_comb begin
    alu = '0;
    alu_ok = 1'b1;
    case (f3)
      3'b000:  alu = (op == OP_OP && ir[30]) ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
      3'b100:  alu = a ^ b;
      3'b101:  alu = ir[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      3'b111:  alu = a & b;
      default: alu_ok = 1'b0;
    endcase
  end

  // Decode: legality, writeback value, next PC, memory access kind
  logic legal, wb_en, is_load, is_store, f7_ok;
  logic [31:0] wb_val, pc_nx, addr_sum;
  always_comb begin
    legal = 1'b0;
    wb_en = 1'b0;
    wb_val = '0;
    is_load = 1'b0;
    is_store = 1'b0;
    pc_nx = pc + 32'd4;
    f7_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
    case (op)
      OP_LUI:   begin legal = 1'b1; wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin legal = 1'b1; wb_en = 1'b1; wb_val = pc + imm_u; end
      OP_JAL:   begin legal = 1'b1; wb_en = 1'b1; wb_val = pc + 32'd4; pc_nx = pc + imm_j; end
      OP_JALR: begin
        legal = (f3 == 3'b000);
        wb_en = 1'b1;
        wb_val = pc + 32'd4;
        pc_nx = (a + imm_i) & ~32'd1;
      end
      OP_BR: begin
        legal = 1'b1;
        case (f3)
          3'b000:  if (a == rs2v) pc_nx = pc + imm_b;
          3'b001:  if (a != rs2v) pc_nx = pc + imm_b;
          3'b100:  if ($signed(a) <  $signed(rs2v)) pc_nx = pc + imm_b;
          3'b101:  if ($signed(a) >= $signed(rs2v)) pc_nx = pc + imm_b;
          default: legal = 1'b0;
        endcase
      end
      OP_LD: begin legal = (f3 == 3'b010); is_load = 1'b1; end
      OP_ST: begin legal = (f3 == 3'b010); is_store = 1'b1; end
      OP_OPI: begin
        legal = alu_ok && (f3 == 3'b001 ? f7 == 7'h00 : (f3 == 3'b101 ? f7_ok : 1'b1));
        wb_en = 1'b1;
        wb_val = alu;
      end
      OP_OP: begin
        legal = alu_ok && f7_ok;
        wb_en = 1'b1;
        wb_val = alu;
      end
      default: legal = 1'b0;
    endcase
    addr_sum = a + ((op == OP_ST) ? imm_s : imm_i);
  end

  // Byte offset bits of the effective address are don't-care
  logic unused_ok;
  assign unused_ok = ^addr_sum[1:0];

  logic exec_st, led_hit, sev_hit, ram_we;
  assign exec_st = (state == EXEC) && legal && is_store;
  assign led_hit = (addr_sum[31:28] == 4'h2) && (addr_sum[27:2] == 26'd0);
  assign sev_hit = (addr_sum[31:28] == 4'h2) && (addr_sum[27:2] == 26'd1);
  assign ram_we  = exec_st && (addr_sum[31:28] == 4'h1);

  // Load data mux, sampled into rdata during MEM
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (addr_q[31:28])
      4'h0: rd_mux = rom[addr_q[9:2]];
      4'h1: rd_mux = ram[addr_q[9:2]];
      4'h2: begin
        if (addr_q[27:2] == 26'd0)      rd_mux = {28'd0, led};
        else if (addr_q[27:2] == 26'd1) rd_mux = {16'd0, sev};
        else if (addr_q[27:2] == 26'd2) rd_mux = {28'd0, io.BTN_PINS[3:0]};
      end
      default: rd_mux = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK_PIN or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // FSM next state; illegal opcodes park the core in HALT
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = !legal ? HALT : (is_load ? MEM : FETCH);
      MEM:     state_nx = WB;
      WB:      state_nx = FETCH;
      default: state_nx = HALT;
    endcase
  end

  // Datapath: fetch, execute/writeback, MMIO stores, load completion
  always_ff @(posedge CLK_PIN or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      rdata <= '0;
      addr_q <= '0;
      led <= '0;
      sev <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: ir <= rom[pc[9:2]];
        EXEC: if (legal) begin
          if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
          if (!is_load) pc <= pc_nx;
          addr_q <= addr_sum[31:2];
          if (exec_st && led_hit) led <= rs2v[3:0];
          if (exec_st && sev_hit) sev <= rs2v[15:0];
        end
        MEM: rdata <= rd_mux;
        WB: begin
          if (rd != 5'd0) regs[rd] <= rdata;
          pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // Data RAM write port; reset drops EXEC so an interrupted store never lands
  always_ff @(posedge CLK_PIN) begin
    if (ram_we) ram[addr_sum[9:2]] <= rs2v;
  end

  // Display scan: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge CLK_PIN or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      digit <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  // Current nibble for the selected digit
  logic [3:0] nib;
  always_comb begin
    case (digit)
      2'd0:    nib = sev[3:0];
      2'd1:    nib = sev[7:4];
      2'd2:    nib = sev[11:8];
      default: nib = sev[15:12];
    endcase
  end

  assign io.LED_PINS        = led;
  assign io.SEVSEG_SEG_PINS = glyph(nib);
  assign io.SEVSEG_SEL_PINS = ~(4'b0001 << digit);
endmodule

// File: tb/tb_niski_dut.sv
// Directed bench for the Niski SoC: programs are encoded here and written into the ROM.
module tb_niski_dut;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  niski_dut_if pins ();
  niski_dut #(.ROM_FILE(""), .SCAN_DIV(4)) dut (.CLK_PIN(clk), .io(pins));

  int errs = 0;
  int checks = 0;
  logic [31:0] prog [0:255];

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, OPI = 7'h13;

  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_lw(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.rom[i] = prog[i];
  endtask

  // Reset pulse of 2 ns placed right after a falling edge
  task automatic do_reset();
    @(negedge clk);
    pins.BTN_PINS[4] = 1'b0;
    #2;
    pins.BTN_PINS[4] = 1'b1;
  endtask

  task automatic wait_scan(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = pins.SEVSEG_SEL_PINS;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && pins.SEVSEG_SEL_PINS == 4'b1110) begin
        ok = 1'b1;
        return;
      end
      prev = pins.SEVSEG_SEL_PINS;
    end
  endtask

  task automatic wait_led_change(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = pins.LED_PINS;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pins.LED_PINS !== prev) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic prog_led();
    clear_prog();
    prog[0] = e_u(20'h20000, 5'd2, LUI);
    prog[1] = e_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    prog[2] = e_s(12'd0, 5'd1, 5'd2);
    load_prog();
  endtask

  task automatic test_reset();
    pins.BTN_PINS = 5'b00000;
    prog_led();
    repeat (3) @(negedge clk);
    checks++; if (pins.LED_PINS !== 4'h0) begin errs++; $display("FAIL reset_led: got %h want 0", pins.LED_PINS); end
    checks++; if (pins.SEVSEG_SEL_PINS !== 4'b1110) begin errs++; $display("FAIL reset_sel: got %b want 1110", pins.SEVSEG_SEL_PINS); end
    checks++; if (pins.SEVSEG_SEG_PINS !== 7'b1000000) begin errs++; $display("FAIL reset_seg: got %b want 1000000", pins.SEVSEG_SEG_PINS); end
    pins.BTN_PINS[4] = 1'b1;
    #1;
    checks++; if (pins.SEVSEG_SEL_PINS !== 4'b1110) begin errs++; $display("FAIL release_sel: got %b want 1110", pins.SEVSEG_SEL_PINS); end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_led();
    prog_led();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin
        checks++; if (pins.LED_PINS !== 4'h0) begin errs++; $display("FAIL led_before_sw: got %b want 0000", pins.LED_PINS); end
      end
      if (i == 6) begin
        checks++; if (pins.LED_PINS !== 4'b0101) begin errs++; $display("FAIL led_after_sw: got %b want 0101", pins.LED_PINS); end
      end
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    pins.BTN_PINS[4] = 1'b0;
    #1;
    checks++; if (pins.LED_PINS !== 4'h0) begin errs++; $display("FAIL reset_clears_led: got %b want 0000", pins.LED_PINS); end
    #1;
    pins.BTN_PINS[4] = 1'b1;
    repeat (5) @(posedge clk);
    do_reset();
    @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'h0) begin errs++; $display("FAIL aborted_store: got %b want 0000", pins.LED_PINS); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'b0101) begin errs++; $display("FAIL restart_led: got %b want 0101", pins.LED_PINS); end
  endtask

  task automatic test_display();
    logic [6:0] seg_exp [4];
    logic [3:0] sel_exp [4];
    bit ok;
    seg_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    sel_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    clear_prog();
    prog[0] = e_u(20'h20000, 5'd2, LUI);
    prog[1] = e_u(20'h00001, 5'd1, LUI);
    prog[2] = e_i(12'h234, 5'd1, 3'b000, 5'd1, OPI);
    prog[3] = e_s(12'd4, 5'd1, 5'd2);
    load_prog();
    do_reset();
    repeat (12) @(posedge clk);
    wait_scan(ok);
    checks++; if (!ok) begin errs++; $display("FAIL scan_wrap: got no 0111->1110 want wrap within 64 cycles"); end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (pins.SEVSEG_SEL_PINS !== sel_exp[j/4] || pins.SEVSEG_SEG_PINS !== seg_exp[j/4]) begin
        errs++;
        $display("FAIL scan_cycle%0d: got sel=%b seg=%b want sel=%b seg=%b", j,
                 pins.SEVSEG_SEL_PINS, pins.SEVSEG_SEG_PINS, sel_exp[j/4], seg_exp[j/4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu();
    logic [3:0] exp [10];
    bit ok;
    exp = '{4'hF, 4'h7, 4'hB, 4'h1, 4'hC, 4'h8, 4'h5, 4'hC, 4'h8, 4'h0};
    clear_prog();
    prog[0]  = e_u(20'h20000, 5'd10, LUI);
    prog[1]  = e_i(12'hFF8, 5'd0, 3'b000, 5'd1, OPI);      // x1 = -8
    prog[2]  = e_i(12'd3, 5'd0, 3'b000, 5'd2, OPI);        // x2 = 3
    prog[3]  = e_i(12'h41D, 5'd1, 3'b101, 5'd3, OPI);      // srai 29 -> -1
    prog[4]  = e_s(12'd0, 5'd3, 5'd10);
    prog[5]  = e_i(12'h01D, 5'd1, 3'b101, 5'd3, OPI);      // srli 29 -> 7
    prog[6]  = e_s(12'd0, 5'd3, 5'd10);
    prog[7]  = e_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3);       // sub 3-(-8) = 11
    prog[8]  = e_s(12'd0, 5'd3, 5'd10);
    prog[9]  = e_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);       // slt -8<3 = 1
    prog[10] = e_s(12'd0, 5'd3, 5'd10);
    prog[11] = e_i(12'hFFF, 5'd2, 3'b100, 5'd3, OPI);      // xori -1 -> ...FC
    prog[12] = e_s(12'd0, 5'd3, 5'd10);
    prog[13] = e_j(21'd8, 5'd3);                           // jal @52 -> x3=56
    prog[14] = e_i(12'd0, 5'd0, 3'b000, 5'd3, OPI);        // skipped
    prog[15] = e_s(12'd0, 5'd3, 5'd10);
    prog[16] = e_b(13'd8, 5'd1, 5'd2, 3'b100);             // blt 3<-8 not taken
    prog[17] = e_i(12'd5, 5'd0, 3'b000, 5'd3, OPI);
    prog[18] = e_s(12'd0, 5'd3, 5'd10);
    prog[19] = e_u(20'h0, 5'd3, AUIPC);                    // x3 = 76
    prog[20] = e_s(12'd0, 5'd3, 5'd10);
    prog[21] = e_i(12'd93, 5'd0, 3'b000, 5'd3, JALR);      // x3 = 88, to 92
    prog[22] = e_i(12'd2, 5'd0, 3'b000, 5'd3, OPI);        // skipped
    prog[23] = e_s(12'd0, 5'd3, 5'd10);
    prog[24] = e_i(12'd5, 5'd0, 3'b000, 5'd0, OPI);        // write to x0
    prog[25] = e_s(12'd0, 5'd0, 5'd10);
    load_prog();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      wait_led_change(ok);
      checks++;
      if (!ok || pins.LED_PINS !== exp[k]) begin
        errs++;
        $display("FAIL alu_store%0d: got %h (changed=%0d) want %h", k, pins.LED_PINS, ok, exp[k]);
      end
    end
  endtask

  task automatic test_count_loop();
    bit ok;
    logic [6:0] seg_exp [4];
    seg_exp = '{7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000};
    clear_prog();
    prog[0]  = e_u(20'h10000, 5'd2, LUI);
    prog[1]  = e_u(20'h20000, 5'd3, LUI);
    prog[2]  = e_i(12'd16, 5'd0, 3'b000, 5'd4, OPI);
    prog[3]  = e_i(12'd15, 5'd0, 3'b000, 5'd5, OPI);
    prog[4]  = e_s(12'd0, 5'd5, 5'd3);                     // LED = F
    prog[5]  = e_i(12'd0, 5'd0, 3'b000, 5'd1, OPI);
    prog[6]  = e_s(12'd0, 5'd1, 5'd2);                     // loop: RAM store
    prog[7]  = e_lw(12'd0, 5'd2, 5'd1);                    // RAM load
    prog[8]  = e_i(12'd1, 5'd1, 3'b000, 5'd1, OPI);
    prog[9]  = e_b(13'h1FF4, 5'd4, 5'd1, 3'b001);          // bne back 12
    prog[10] = e_s(12'd0, 5'd1, 5'd3);
    prog[11] = e_s(12'd4, 5'd1, 5'd3);
    load_prog();
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'hF) begin errs++; $display("FAIL count_led_init: got %h want F", pins.LED_PINS); end
    repeat (590) @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'h0) begin errs++; $display("FAIL count_led: got %h want 0", pins.LED_PINS); end
    wait_scan(ok);
    checks++; if (!ok) begin errs++; $display("FAIL count_scan: got no wrap want wrap within 64 cycles"); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (pins.SEVSEG_SEG_PINS !== seg_exp[d]) begin
        errs++;
        $display("FAIL count_sev_digit%0d: got %b want %b", d, pins.SEVSEG_SEG_PINS, seg_exp[d]);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_buttons_halt();
    clear_prog();
    prog[0] = e_u(20'h20000, 5'd3, LUI);
    prog[1] = e_lw(12'd8, 5'd3, 5'd1);
    prog[2] = e_s(12'd0, 5'd1, 5'd3);
    load_prog();
    pins.BTN_PINS[3:0] = 4'b1010;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'b1010) begin errs++; $display("FAIL btn_led: got %b want 1010", pins.LED_PINS); end
    pins.BTN_PINS[3:0] = 4'b0101;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'b1010) begin errs++; $display("FAIL halt_hold: got %b want 1010", pins.LED_PINS); end
    @(negedge clk);
    pins.BTN_PINS[4] = 1'b0;
    #1;
    checks++; if (pins.LED_PINS !== 4'h0) begin errs++; $display("FAIL halt_reset: got %b want 0000", pins.LED_PINS); end
    #1;
    pins.BTN_PINS[4] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (pins.LED_PINS !== 4'b0101) begin errs++; $display("FAIL restart_btn: got %b want 0101", pins.LED_PINS); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_reset_abort();
    test_display();
    test_alu();
    test_count_loop();
    test_buttons_halt();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
